// File: rtl/freq_meter.sv
// Gated edge counter: counts synchronized rising edges of sig_in over
// GATE_CYCLES sys_clk cycles and publishes each window with a valid strobe.
module freq_meter #(
    parameter int unsigned GATE_CYCLES = 50000000,
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             sig_in,
    input  logic             enable,
    output logic [CNT_W-1:0] freq_out,
    output logic             freq_valid,
    output logic             overflow,
    output logic             no_signal,
    output logic             busy
);

    localparam int unsigned GW = $clog2(GATE_CYCLES);
    localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);
    localparam logic [GW-1:0] GATE_ONE = GW'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        GATE,
        LATCH
    } state_e;

    state_e                 state_q;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic [GW-1:0]          gate_cnt_q;
    logic [CNT_W-1:0]       edge_cnt_q;
    logic [CNT_W-1:0]       edge_cnt_d;
    logic                   ovf_q;
    logic                   ovf_d;
    logic [CNT_W-1:0]       freq_out_q;
    logic                   freq_valid_q;
    logic                   overflow_q;
    logic                   no_signal_q;
    logic                   busy_q;
    logic                   rise;

    assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    // Saturating count; a rise that would wrap only flags overflow.
    always_comb begin
        edge_cnt_d = edge_cnt_q;
        ovf_d      = ovf_q;
        if (rise) begin
            if (edge_cnt_q == CNT_MAX) begin
                ovf_d = 1'b1;
            end else begin
                edge_cnt_d = edge_cnt_q + CNT_ONE;
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q      <= IDLE;
            gate_cnt_q   <= '0;
            edge_cnt_q   <= '0;
            ovf_q        <= 1'b0;
            freq_out_q   <= '0;
            freq_valid_q <= 1'b0;
            overflow_q   <= 1'b0;
            no_signal_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            freq_valid_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (enable) begin
                        state_q    <= GATE;
                        busy_q     <= 1'b1;
                        gate_cnt_q <= '0;
                        edge_cnt_q <= '0;
                        ovf_q      <= 1'b0;
                    end
                end
                GATE: begin
                    if (!enable) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        gate_cnt_q <= gate_cnt_q + GATE_ONE;
                        edge_cnt_q <= edge_cnt_d;
                        ovf_q      <= ovf_d;
                        if (gate_cnt_q == GATE_LAST) begin
                            state_q <= LATCH;
                        end
                    end
                end
                LATCH: begin
                    freq_out_q   <= edge_cnt_q;
                    overflow_q   <= ovf_q;
                    no_signal_q  <= (edge_cnt_q == '0);
                    freq_valid_q <= 1'b1;
                    gate_cnt_q   <= '0;
                    edge_cnt_q   <= '0;
                    ovf_q        <= 1'b0;
                    if (enable) begin
                        state_q <= GATE;
                    end else begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign freq_out   = freq_out_q;
    assign freq_valid = freq_valid_q;
    assign overflow   = overflow_q;
    assign no_signal  = no_signal_q;
    assign busy       = busy_q;

endmodule
